// File: rtl/bk_pkg.sv
// Shared types and constants for the save-state backup RAM sequencer.
//   bk_state_t      : sequencer FSM state encoding (IDLE, REQ, XFER)
//   BK_SECTOR_BYTES : bytes moved per SD sector transfer
//   BK_SECT_LOG2    : default log2 of sectors per save slot
//   BK_SLOT_W       : default width of the slot select
package bk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } bk_state_t;

    localparam int unsigned BK_SECTOR_BYTES = 512;
    localparam int unsigned BK_SECT_LOG2    = 6;
    localparam int unsigned BK_SLOT_W       = 2;

endpackage

// File: rtl/bk_sequencer.sv
// Backup RAM save/load sequencer. Tracks whether a writable save image is
// mounted, and on a load/save trigger moves 2^SECT_LOG2 consecutive sectors
// of the selected slot over the hps_io sd_rd/sd_wr/sd_ack handshake.
// Ports:
//   clk_sys, RESET_n          : clock, asynchronous active-low reset
//   downloading               : ROM download in progress
//   img_mounted, img_size_nz,
//   img_readonly              : image mount strobe and attributes
//   bk_load, bk_save          : load/save request levels
//   slot                      : save slot, sampled at trigger
//   sd_ack                    : hps_io transfer acknowledge
//   sd_lba, sd_rd, sd_wr      : sector request to hps_io
//   bk_ena                    : writable save image mounted
//   bk_state, bk_loading      : sequence busy / busy with a load
//   bk_error                  : last sequence aborted by ack timeout (sticky)
module bk_sequencer
    import bk_pkg::*;
#(
    parameter int unsigned SECT_LOG2 = BK_SECT_LOG2,
    parameter int unsigned SLOT_W    = BK_SLOT_W,
    parameter int unsigned TMO_W     = 24
) (
    input  logic              clk_sys,
    input  logic              RESET_n,
    input  logic              downloading,
    input  logic              img_mounted,
    input  logic              img_size_nz,
    input  logic              img_readonly,
    input  logic              bk_load,
    input  logic              bk_save,
    input  logic [SLOT_W-1:0] slot,
    input  logic              sd_ack,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    output logic              bk_ena,
    output logic              bk_state,
    output logic              bk_loading,
    output logic              bk_error
);

    bk_state_t            fsm_q, fsm_d;
    logic [31:0]          lba_q, lba_d;
    logic                 rd_q, rd_d, wr_q, wr_d;
    logic                 busy_q, busy_d, loading_q, loading_d, error_q, error_d;
    logic                 ena_q, ena_d;
    logic [TMO_W-1:0]     wdog_q, wdog_d, wdog_inc;
    logic                 old_load_q, old_save_q, old_ack_q, old_dl_q;

    logic                 load_t, save_t, ack_rise, ack_fall;
    logic [31:0]          lba_base;
    logic [SECT_LOG2-1:0] sect, sect_inc;

    assign load_t   = bk_load & ena_q & ~old_load_q;
    assign save_t   = bk_save & ena_q & ~old_save_q;
    assign ack_rise = sd_ack & ~old_ack_q;
    assign ack_fall = ~sd_ack & old_ack_q;

    assign lba_base = 32'(slot) << SECT_LOG2;
    assign sect     = lba_q[SECT_LOG2-1:0];
    // Only the sector field advances; the slot bits never see a carry.
    assign sect_inc = sect + 1'b1;
    assign wdog_inc = wdog_q + 1'b1;

    always_comb begin
        fsm_d     = fsm_q;
        lba_d     = lba_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        busy_d    = busy_q;
        loading_d = loading_q;
        error_d   = error_q;
        wdog_d    = wdog_q;
        ena_d     = ena_q;

        // A mount seen in the same cycle as the download edge wins.
        if (downloading & ~old_dl_q) begin
            ena_d = 1'b0;
        end
        if (downloading & img_mounted & img_size_nz & ~img_readonly) begin
            ena_d = 1'b1;
        end

        case (fsm_q)
            IDLE: begin
                if (load_t | save_t) begin
                    lba_d     = lba_base;
                    rd_d      = load_t;
                    wr_d      = ~load_t;
                    busy_d    = 1'b1;
                    loading_d = load_t;
                    error_d   = 1'b0;
                    wdog_d    = '0;
                    fsm_d     = REQ;
                end
            end
            REQ: begin
                if (ack_rise) begin
                    rd_d  = 1'b0;
                    wr_d  = 1'b0;
                    fsm_d = XFER;
                end else begin
                    wdog_d = wdog_inc;
                    if (&wdog_inc) begin
                        rd_d      = 1'b0;
                        wr_d      = 1'b0;
                        error_d   = 1'b1;
                        busy_d    = 1'b0;
                        loading_d = 1'b0;
                        fsm_d     = IDLE;
                    end
                end
            end
            XFER: begin
                if (ack_fall) begin
                    if (&sect) begin
                        busy_d    = 1'b0;
                        loading_d = 1'b0;
                        fsm_d     = IDLE;
                    end else begin
                        lba_d  = {lba_q[31:SECT_LOG2], sect_inc};
                        rd_d   = loading_q;
                        wr_d   = ~loading_q;
                        wdog_d = '0;
                        fsm_d  = REQ;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            fsm_q      <= IDLE;
            lba_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            loading_q  <= 1'b0;
            error_q    <= 1'b0;
            wdog_q     <= '0;
            ena_q      <= 1'b0;
            old_load_q <= 1'b0;
            old_save_q <= 1'b0;
            old_ack_q  <= 1'b0;
            old_dl_q   <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            lba_q      <= lba_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            loading_q  <= loading_d;
            error_q    <= error_d;
            wdog_q     <= wdog_d;
            ena_q      <= ena_d;
            old_load_q <= bk_load & ena_q;
            old_save_q <= bk_save & ena_q;
            old_ack_q  <= sd_ack;
            old_dl_q   <= downloading;
        end
    end

    assign sd_lba     = lba_q;
    assign sd_rd      = rd_q;
    assign sd_wr      = wr_q;
    assign bk_ena     = ena_q;
    assign bk_state   = busy_q;
    assign bk_loading = loading_q;
    assign bk_error   = error_q;

endmodule

// File: tb/tb_bk_sequencer.sv
// Self-checking bench for bk_sequencer: sequence-level reference model,
// per-cycle output comparison, HPS ack responder and request recorder.
module tb_bk_sequencer;

    localparam int SECT_LOG2 = 6;
    localparam int SLOT_W    = 2;
    localparam int TMO_W     = 4;
    localparam int SECTORS   = 1 << SECT_LOG2;
    localparam int TMO_LIMIT = (1 << TMO_W) - 1;

    logic              clk_sys, RESET_n;
    logic              downloading, img_mounted, img_size_nz, img_readonly;
    logic              bk_load, bk_save;
    logic [SLOT_W-1:0] slot;
    logic              sd_ack;
    logic [31:0]       sd_lba;
    logic              sd_rd, sd_wr, bk_ena, bk_state, bk_loading, bk_error;

    int tests = 0;
    int fails = 0;

    bk_sequencer #(.SECT_LOG2(SECT_LOG2), .SLOT_W(SLOT_W), .TMO_W(TMO_W)) dut (
        .clk_sys(clk_sys), .RESET_n(RESET_n), .downloading(downloading),
        .img_mounted(img_mounted), .img_size_nz(img_size_nz), .img_readonly(img_readonly),
        .bk_load(bk_load), .bk_save(bk_save), .slot(slot), .sd_ack(sd_ack),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .bk_ena(bk_ena),
        .bk_state(bk_state), .bk_loading(bk_loading), .bk_error(bk_error)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: sequence of sectors per trigger ----------------
    bit   m_ena, m_busy, m_loading, m_err, m_req;
    bit   m_prev_load, m_prev_save, m_prev_ack, m_prev_dl;
    int   m_slot, m_sector, m_wait;

    wire m_load_edge = bk_load && m_ena && !m_prev_load;
    wire m_save_edge = bk_save && m_ena && !m_prev_save;
    wire m_ack_rise  = sd_ack && !m_prev_ack;
    wire m_ack_fall  = !sd_ack && m_prev_ack;
    wire m_mount_ok  = downloading && img_mounted && img_size_nz && !img_readonly;
    wire m_dl_rise   = downloading && !m_prev_dl;

    always @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            m_ena <= 0; m_busy <= 0; m_loading <= 0; m_err <= 0; m_req <= 0;
            m_prev_load <= 0; m_prev_save <= 0; m_prev_ack <= 0; m_prev_dl <= 0;
            m_slot <= 0; m_sector <= 0; m_wait <= 0;
        end else begin
            m_prev_load <= bk_load && m_ena;
            m_prev_save <= bk_save && m_ena;
            m_prev_ack  <= sd_ack;
            m_prev_dl   <= downloading;
            if (m_mount_ok) m_ena <= 1;
            else if (m_dl_rise) m_ena <= 0;
            if (!m_busy) begin
                if (m_load_edge || m_save_edge) begin
                    m_busy <= 1; m_loading <= m_load_edge; m_err <= 0;
                    m_slot <= int'(slot); m_sector <= 0; m_req <= 1; m_wait <= 0;
                end
            end else if (m_req) begin
                if (m_ack_rise) m_req <= 0;
                else if (m_wait + 1 == TMO_LIMIT) begin
                    m_req <= 0; m_busy <= 0; m_loading <= 0; m_err <= 1;
                end else m_wait <= m_wait + 1;
            end else if (m_ack_fall) begin
                if (m_sector == SECTORS - 1) begin
                    m_busy <= 0; m_loading <= 0;
                end else begin
                    m_sector <= m_sector + 1; m_req <= 1; m_wait <= 0;
                end
            end
        end
    end

    // ---------------- HPS ack responder ----------------
    int ack_dly = 3, ack_hi = 4, ack_cnt = 0;
    bit hold_ack = 0, ack_active = 0;

    initial begin
        sd_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (!RESET_n) begin
                ack_active = 0; ack_cnt = 0; sd_ack = 1'b0;
            end else if (ack_active) begin
                ack_cnt++;
                if (ack_cnt == ack_dly) sd_ack = 1'b1;
                else if (ack_cnt == ack_dly + ack_hi) begin
                    sd_ack = 1'b0; ack_active = 0;
                end
            end else if ((sd_rd || sd_wr) && !hold_ack) begin
                ack_active = 1; ack_cnt = 0;
            end
        end
    end

    // ---------------- per-cycle compare and request recorder ----------------
    logic [31:0] req_lba[$];
    int rd_starts = 0, wr_starts = 0, wr_cycles = 0;
    bit loading_seen = 0, prev_req = 0;

    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            if (RESET_n) begin
                check("cyc bk_ena", bk_ena, m_ena);
                check("cyc bk_state", bk_state, m_busy);
                check("cyc bk_loading", bk_loading, m_loading);
                check("cyc bk_error", bk_error, m_err);
                check("cyc sd_rd", sd_rd, m_busy && m_req && m_loading);
                check("cyc sd_wr", sd_wr, m_busy && m_req && !m_loading);
                check("cyc sd_lba", sd_lba, 32'(m_slot * SECTORS + m_sector));
                check("cyc rd_wr_excl", sd_rd & sd_wr, 1'b0);
                if ((sd_rd || sd_wr) && !prev_req) begin
                    req_lba.push_back(sd_lba);
                    if (sd_rd) rd_starts++;
                    if (sd_wr) wr_starts++;
                end
                if (sd_wr) wr_cycles++;
                if (bk_loading) loading_seen = 1;
                prev_req = sd_rd || sd_wr;
            end else prev_req = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic clear_rec();
        req_lba.delete();
        rd_starts = 0; wr_starts = 0; wr_cycles = 0; loading_seen = 0;
    endtask

    task automatic pulse(input bit ld, input bit sv);
        bk_load = ld; bk_save = sv;
        cyc(1);
        bk_load = 0; bk_save = 0;
        cyc(1);
    endtask

    task automatic wait_done(input string name, input bit jiggle);
        int k = 0;
        while (bk_state !== 1'b0 && k < 3000) begin
            if (jiggle) begin
                bk_load = 1'($urandom_range(0, 1));
                bk_save = 1'($urandom_range(0, 1));
                slot    = SLOT_W'($urandom);
            end
            cyc(1);
            k++;
        end
        bk_load = 0; bk_save = 0;
        check({name, " finished in bound"}, k < 3000, 1);
    endtask

    task automatic check_seq(input string name, input bit is_load, input int base);
        bit ok = 1;
        check({name, " count"}, req_lba.size(), SECTORS);
        for (int i = 0; i < req_lba.size(); i++)
            if (req_lba[i] !== 32'(base + i)) ok = 0;
        check({name, " lba order"}, ok, 1);
        check({name, " rd starts"}, rd_starts, is_load ? SECTORS : 0);
        check({name, " wr starts"}, wr_starts, is_load ? 0 : SECTORS);
        check({name, " loading seen"}, loading_seen, is_load);
    endtask

    task automatic mount_writable();
        downloading = 1; img_mounted = 1; img_size_nz = 1; img_readonly = 0;
        cyc(1);
        img_mounted = 0;
        cyc(1);
        downloading = 0;
        cyc(1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        RESET_n = 0; downloading = 0; img_mounted = 0; img_size_nz = 0; img_readonly = 0;
        bk_load = 0; bk_save = 0; slot = '0;
        cyc(3);
        check("reset sd_lba", sd_lba, 32'h0);
        check("reset rd/wr", {sd_rd, sd_wr}, 2'b00);
        check("reset flags", {bk_ena, bk_state, bk_loading, bk_error}, 4'b0000);
        RESET_n = 1;
        cyc(2);

        // No image mounted: save request is ignored.
        pulse(0, 1);
        cyc(4);
        check("no ena state", bk_state, 1'b0);
        check("no ena wr", sd_wr, 1'b0);

        // Read-only mount during download keeps bk_ena low.
        downloading = 1; img_mounted = 1; img_size_nz = 1; img_readonly = 1;
        cyc(1);
        img_mounted = 0;
        cyc(1);
        downloading = 0;
        cyc(1);
        check("readonly ena", bk_ena, 1'b0);

        mount_writable();
        check("writable ena", bk_ena, 1'b1);

        // Save of slot 1.
        slot = 2'd1; clear_rec();
        pulse(0, 1);
        wait_done("save1", 0);
        check_seq("save1", 0, 32'h40);

        // Load of slot 3 with the level held; slot changes mid-sequence.
        slot = 2'd3; clear_rec();
        bk_load = 1;
        cyc(2);
        slot = 2'd0;
        k = 0;
        while (bk_state !== 1'b0 && k < 3000) begin cyc(1); k++; end
        check("load3 finished in bound", k < 3000, 1);
        check_seq("load3", 1, 32'hC0);
        cyc(5);
        check("held level no retrigger", bk_state, 1'b0);
        bk_load = 0;
        cyc(2);

        // Load and save together: load wins, later save edge ignored.
        slot = 2'd2; clear_rec();
        pulse(1, 1);
        cyc(20);
        pulse(0, 1);
        wait_done("both", 0);
        check_seq("both", 1, 32'h80);

        // Randomized sequences, random ack timing and input noise.
        for (int n = 0; n < 4; n++) begin
            bit ld;
            int sl;
            ack_dly = $urandom_range(1, 6);
            ack_hi  = $urandom_range(1, 4);
            ld = 1'($urandom_range(0, 1));
            sl = $urandom_range(0, 3);
            slot = SLOT_W'(sl); clear_rec();
            pulse(ld, !ld);
            wait_done("rand", 1);
            cyc(2);
            check_seq("rand", ld, sl * SECTORS);
        end
        ack_dly = 3; ack_hi = 4;

        // Ack withheld: watchdog aborts the request.
        hold_ack = 1; slot = 2'd1; clear_rec();
        pulse(0, 1);
        wait_done("timeout", 0);
        check("timeout wr cycles", wr_cycles, TMO_LIMIT);
        check("timeout requests", req_lba.size(), 1);
        check("timeout error", bk_error, 1'b1);
        check("timeout wr low", sd_wr, 1'b0);
        hold_ack = 0;
        cyc(2);

        // Next trigger clears the error; reset at sector 10 abandons it.
        slot = 2'd2; clear_rec();
        pulse(1, 0);
        check("retrigger clears error", bk_error, 1'b0);
        check("retrigger first lba", req_lba.size() > 0 ? req_lba[0] : 32'hDEAD, 32'h80);
        k = 0;
        while (req_lba.size() < 11 && k < 2000) begin cyc(1); k++; end
        check("reach sector 10", k < 2000, 1);
        check("sector 10 lba", sd_lba, 32'h8A);
        #2 RESET_n = 0;
        #1;
        check("async reset lba", sd_lba, 32'h0);
        check("async reset outs", {sd_rd, sd_wr, bk_ena, bk_state, bk_loading, bk_error},
              6'b0);
        cyc(2);
        RESET_n = 1;
        cyc(2);
        mount_writable();
        clear_rec();
        pulse(1, 0);
        wait_done("post reset", 0);
        check_seq("post reset", 1, 32'h80);

        // Download rising edge drops bk_ena; mount in the same cycle keeps it.
        downloading = 1;
        cyc(2);
        check("dl edge clears ena", bk_ena, 1'b0);
        downloading = 0;
        cyc(1);
        downloading = 1; img_mounted = 1;
        cyc(1);
        img_mounted = 0;
        cyc(1);
        check("set wins over clear", bk_ena, 1'b1);
        downloading = 0;
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
